scsi_xfer_sm: RTL and testbench
===============================

# scsi_xfer_sm

Parametrised successor to the SCSI bus sequencer. It arbitrates CPU register accesses and DMA byte transfers on the SCSI controller's 8-bit port. It generates chip-select, read/write strobes of configurable width, DACK, and data-path steering. It also tracks the byte lane within a FIFO word of `LANES` bytes, so FIFO pointer increments happen automatically at word boundaries. The block sits between the CPU bus interface, the FIFO and the external SCSI controller.

## Interface
Parameters:
- `LANES`, 4: bytes per FIFO word; legal values 1, 2, 4, 8.
- `STROBE_CYC`, 2: RE/WE active width in CPUCLK cycles; must be ≥1.
- `RECOVERY_CYC`, 1: idle cycles after each DMA strobe; must be ≥1.

Ports:
- `CPUCLK` in 1: sole clock; all state changes on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `CPUREQ` in 1: CPU requests a SCSI register cycle.
- `RW` in 1: 1 = CPU read, 0 = CPU write.
- `DMADIR` in 1: 1 = SCSI→FIFO, 0 = FIFO→SCSI.
- `DREQ_` in 1: controller DMA request, active-low.
- `FIFOFULL`, `FIFOEMPTY` in 1 each: FIFO status.
- `FLUSH` in 1: single-cycle partial-word flush request (see Configuration).
- `SCSI_CS` out 1: controller chip-select, active-high.
- `RE`, `WE` out 1 each: controller read and write strobes.
- `DACK` out 1: DMA acknowledge.
- `S2CPU`, `CPU2S`, `S2F`, `F2S` out 1 each: data-path steering.
- `DSACK` out 1: CPU cycle complete.
- `INCBO` out 1: byte-pointer increment pulse.
- `INCNI`, `INCNO` out 1 each: FIFO in/out word-pointer increment pulses.
- `LANE` out max(1,$clog2(LANES)): current byte lane.

## Operation
- `CPUREQ` and `DREQ_` each pass through one register stage (`CCPUREQ`, `CDREQ_`). All decisions use the registered copies.
- All outputs are flops loaded from the next-state decode, so they change on the same edge as `STATE`. No output is combinational.
- States: `IDLE`, `CPU_SETUP`, `CPU_STROBE`, `CPU_ACK`, `DMA_SETUP`, `DMA_STROBE`, `DMA_RECOV`, `FLUSH`.
- From `IDLE`, CPU path:
  - `CCPUREQ=1` → `CPU_SETUP`. CPU requests have priority over DMA when both are pending in the same cycle.
- From `IDLE`, DMA path (only when `CCPUREQ=0`):
  - `CDREQ_=0` and `DMADIR=1` and `FIFOFULL=0` → `DMA_SETUP`.
  - `CDREQ_=0` and `DMADIR=0` and `FIFOEMPTY=0` → `DMA_SETUP`.
  - If the FIFO blocks the transfer, the block stays in `IDLE` with no outputs asserted.
- `RW` is latched on entry to `CPU_SETUP`; `DMADIR` is latched on entry to `DMA_SETUP`. Later changes to either are ignored until `IDLE`.
- `CPU_SETUP`, 1 cycle: `SCSI_CS`=1, plus `S2CPU` (read) or `CPU2S` (write).
- `CPU_STROBE`, `STROBE_CYC` cycles: setup outputs held, plus `RE` (read) or `WE` (write).
- `CPU_ACK`: `SCSI_CS`, `RE`, `WE` drop; `DSACK`=1; `S2CPU` is held during reads. The state holds until `CCPUREQ=0`, then → `IDLE`.
- `DMA_SETUP`, 1 cycle: `DACK`=1, plus `S2F` (DMADIR=1) or `F2S` (DMADIR=0).
- `DMA_STROBE`, `STROBE_CYC` cycles: `DACK` and steering held, plus `RE` (DMADIR=1) or `WE` (DMADIR=0).
- `DMA_RECOV`, `RECOVERY_CYC` cycles: all strobes low, `DACK`=0. In the first cycle only:
  - `INCBO`=1.
  - `LANE` increments modulo `LANES`.
  - If `LANE` was `LANES-1`, `INCNI` (DMADIR=1) or `INCNO` (DMADIR=0) also pulses for that cycle.
  - Exit → `IDLE`.
- With `LANES=1`, every byte pulses `INCNI`/`INCNO` and `LANE` stays 0.
- `LANE` changes only in `DMA_RECOV`, `FLUSH` or reset. CPU cycles never touch it.

## Timing
- Reset values: `STATE`=`IDLE`, `LANE`=0, all outputs 0.
- Reset mid-cycle: strobes, `DACK` and `SCSI_CS` drop asynchronously. No `INCBO`/`INCNI`/`INCNO` pulse is produced, and the partial lane count is lost.
- CPU cycle: `CPUREQ` high before edge 0 gives:
  - `SCSI_CS` at edge 1;
  - `RE`/`WE` from edge 2 through edge 1+`STROBE_CYC`;
  - `DSACK` at edge 2+`STROBE_CYC`.
- DMA byte: total length is 1+`STROBE_CYC`+`RECOVERY_CYC` cycles. The earliest next `DACK` comes 2 cycles after returning to `IDLE`, because `DREQ_` is re-sampled.
- `INCBO`, `INCNI` and `INCNO` are exactly one cycle wide.
- Back-to-back DMA is allowed while `CDREQ_=0`. A `CPUREQ` arriving mid-DMA is served after the current byte completes.

## Configuration
- `SCSI_XFER_FLUSH_EN` defined:
  - In `IDLE`, `FLUSH`=1 with `LANE`≠0 and latched `DMADIR`=1 → `FLUSH` state for 1 cycle: `INCNI`=1, `LANE`←0, then → `IDLE`.
  - `FLUSH` with `LANE`=0 is ignored.
  - `FLUSH` outside `IDLE` is dropped; it is not queued.
- Not defined: the `FLUSH` port exists but is ignored, and the `FLUSH` state is unreachable. Residual bytes remain until `RESET`.

## Test plan
- CPU read, `STROBE_CYC`=2 → `SCSI_CS` high at edges 1–3, `RE` at edges 2–3, `S2CPU` at edges 1 onward, `DSACK` at edge 4; returns to `IDLE` one cycle after `CPUREQ` falls.
- `LANES`=4, DMADIR=1, `DREQ_` held low for 8 bytes → 8 `INCBO` pulses, `INCNI` on bytes 4 and 8, `LANE` sequence 1,2,3,0,1,2,3,0.
- DMADIR=0 with `FIFOEMPTY`=1 and `DREQ_` low → no `DACK` ever. Deassert `FIFOEMPTY` → `DACK` asserted 1 cycle later.
- `CPUREQ` and `DREQ_` asserted on the same edge → CPU cycle runs first, DMA byte starts after `DSACK` is released.
- `RESET` pulsed during `DMA_STROBE` → `RE`/`DACK` low immediately, `LANE`=0, no increment pulses.
- With `SCSI_XFER_FLUSH_EN`: after 3 bytes with DMADIR=1, pulse `FLUSH` → one `INCNI` pulse, `LANE`=0. Without the macro: no `INCNI`, `LANE` stays 3.

Source files
------------

// File: rtl/scsi_xfer_sm.sv
// scsi_xfer_sm: sequences CPU register cycles and DMA byte transfers on the SCSI controller port.
// Optional: define SCSI_XFER_FLUSH_EN to enable the partial-word FLUSH state.
module scsi_xfer_sm #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned STROBE_CYC   = 2,
    parameter int unsigned RECOVERY_CYC = 1,
    localparam int unsigned LaneW       = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             CPUCLK,
    input  logic             RESET,
    input  logic             CPUREQ,
    input  logic             RW,
    input  logic             DMADIR,
    input  logic             DREQ_,
    input  logic             FIFOFULL,
    input  logic             FIFOEMPTY,
    input  logic             FLUSH,
    output logic             SCSI_CS,
    output logic             RE,
    output logic             WE,
    output logic             DACK,
    output logic             S2CPU,
    output logic             CPU2S,
    output logic             S2F,
    output logic             F2S,
    output logic             DSACK,
    output logic             INCBO,
    output logic             INCNI,
    output logic             INCNO,
    output logic [LaneW-1:0] LANE
);

    localparam int unsigned MaxCyc = (STROBE_CYC > RECOVERY_CYC) ? STROBE_CYC : RECOVERY_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0]  StrobeLoad = CntW'(STROBE_CYC - 1);
    localparam logic [CntW-1:0]  RecovLoad  = CntW'(RECOVERY_CYC - 1);
    localparam logic [LaneW-1:0] LaneLast   = LaneW'(LANES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCpuSetup,
        StCpuStrobe,
        StCpuAck,
        StDmaSetup,
        StDmaStrobe,
        StDmaRecov,
        StFlush
    } state_e;

    state_e           state_q, state_d;
    logic             cpureq_q;
    logic             dreq_n_q, dreq_n_d;
    logic             rw_q, rw_d;
    logic             dir_q, dir_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [LaneW-1:0] lane_q, lane_d;
    logic             flush_go;
    logic             word_wrap;

    logic scsi_cs_q, scsi_cs_d;
    logic re_q, re_d;
    logic we_q, we_d;
    logic dack_q, dack_d;
    logic s2cpu_q, s2cpu_d;
    logic cpu2s_q, cpu2s_d;
    logic s2f_q, s2f_d;
    logic f2s_q, f2s_d;
    logic dsack_q, dsack_d;
    logic incbo_q, incbo_d;
    logic incni_q, incni_d;
    logic incno_q, incno_d;

`ifdef SCSI_XFER_FLUSH_EN
    assign flush_go = FLUSH && (lane_q != '0) && dir_q;
`else
    logic flush_unused;
    assign flush_unused = FLUSH;
    assign flush_go     = 1'b0;
`endif

    // DREQ_ is re-sampled only while idle, so a stale request never restarts a byte early.
    assign dreq_n_d = (state_q == StIdle) ? DREQ_ : 1'b1;

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        case (state_q)
            StIdle: begin
                if (cpureq_q) begin
                    state_d = StCpuSetup;
                    rw_d    = RW;
                end else if (!dreq_n_q && (DMADIR ? !FIFOFULL : !FIFOEMPTY)) begin
                    state_d = StDmaSetup;
                    dir_d   = DMADIR;
                end else if (flush_go) begin
                    state_d = StFlush;
                    lane_d  = '0;
                end
            end
            StCpuSetup: begin
                state_d = StCpuStrobe;
                cnt_d   = StrobeLoad;
            end
            StCpuStrobe: begin
                if (cnt_q == '0) state_d = StCpuAck;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StCpuAck: begin
                if (!cpureq_q) state_d = StIdle;
            end
            StDmaSetup: begin
                state_d = StDmaStrobe;
                cnt_d   = StrobeLoad;
            end
            StDmaStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StDmaRecov;
                    cnt_d   = RecovLoad;
                    lane_d  = (lane_q == LaneLast) ? '0 : lane_q + LaneW'(1);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDmaRecov: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode the next state so they switch on the same edge as the state register.
    always_comb begin
        scsi_cs_d = (state_d == StCpuSetup) || (state_d == StCpuStrobe);
        s2cpu_d   = rw_d && ((state_d == StCpuSetup) || (state_d == StCpuStrobe) ||
                             (state_d == StCpuAck));
        cpu2s_d   = !rw_d && scsi_cs_d;
        dack_d    = (state_d == StDmaSetup) || (state_d == StDmaStrobe);
        s2f_d     = dack_d && dir_d;
        f2s_d     = dack_d && !dir_d;
        re_d      = ((state_d == StCpuStrobe) && rw_d) || ((state_d == StDmaStrobe) && dir_d);
        we_d      = ((state_d == StCpuStrobe) && !rw_d) || ((state_d == StDmaStrobe) && !dir_d);
        dsack_d   = (state_d == StCpuAck);
        incbo_d   = (state_q == StDmaStrobe) && (state_d == StDmaRecov);
        word_wrap = incbo_d && (lane_q == LaneLast);
        incni_d   = (word_wrap && dir_q) || (state_d == StFlush);
        incno_d   = word_wrap && !dir_q;
    end

    always_ff @(posedge CPUCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            cpureq_q  <= 1'b0;
            dreq_n_q  <= 1'b1;
            rw_q      <= 1'b0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            lane_q    <= '0;
            scsi_cs_q <= 1'b0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            dack_q    <= 1'b0;
            s2cpu_q   <= 1'b0;
            cpu2s_q   <= 1'b0;
            s2f_q     <= 1'b0;
            f2s_q     <= 1'b0;
            dsack_q   <= 1'b0;
            incbo_q   <= 1'b0;
            incni_q   <= 1'b0;
            incno_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpureq_q  <= CPUREQ;
            dreq_n_q  <= dreq_n_d;
            rw_q      <= rw_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            scsi_cs_q <= scsi_cs_d;
            re_q      <= re_d;
            we_q      <= we_d;
            dack_q    <= dack_d;
            s2cpu_q   <= s2cpu_d;
            cpu2s_q   <= cpu2s_d;
            s2f_q     <= s2f_d;
            f2s_q     <= f2s_d;
            dsack_q   <= dsack_d;
            incbo_q   <= incbo_d;
            incni_q   <= incni_d;
            incno_q   <= incno_d;
        end
    end

    assign SCSI_CS = scsi_cs_q;
    assign RE      = re_q;
    assign WE      = we_q;
    assign DACK    = dack_q;
    assign S2CPU   = s2cpu_q;
    assign CPU2S   = cpu2s_q;
    assign S2F     = s2f_q;
    assign F2S     = f2s_q;
    assign DSACK   = dsack_q;
    assign INCBO   = incbo_q;
    assign INCNI   = incni_q;
    assign INCNO   = incno_q;
    assign LANE    = lane_q;

endmodule

// File: tb/tb_scsi_xfer_sm.sv
// tb_scsi_xfer_sm: directed cycle-by-cycle checks of scsi_xfer_sm with default parameters.
`timescale 1ns/1ps
module tb_scsi_xfer_sm;

    localparam logic [11:0] O_CS    = 12'h800;
    localparam logic [11:0] O_RE    = 12'h400;
    localparam logic [11:0] O_WE    = 12'h200;
    localparam logic [11:0] O_DACK  = 12'h100;
    localparam logic [11:0] O_S2CPU = 12'h080;
    localparam logic [11:0] O_CPU2S = 12'h040;
    localparam logic [11:0] O_S2F   = 12'h020;
    localparam logic [11:0] O_F2S   = 12'h010;
    localparam logic [11:0] O_DSACK = 12'h008;
    localparam logic [11:0] O_INCBO = 12'h004;
    localparam logic [11:0] O_INCNI = 12'h002;
    localparam logic [11:0] O_INCNO = 12'h001;

    logic       CPUCLK = 1'b0;
    logic       RESET, CPUREQ, RW, DMADIR, DREQ_, FIFOFULL, FIFOEMPTY, FLUSH;
    logic       SCSI_CS, RE, WE, DACK, S2CPU, CPU2S, S2F, F2S, DSACK, INCBO, INCNI, INCNO;
    logic [1:0] LANE;
    logic [11:0] outs;

    int checks   = 0;
    int failures = 0;

    scsi_xfer_sm dut (
        .CPUCLK   (CPUCLK),
        .RESET    (RESET),
        .CPUREQ   (CPUREQ),
        .RW       (RW),
        .DMADIR   (DMADIR),
        .DREQ_    (DREQ_),
        .FIFOFULL (FIFOFULL),
        .FIFOEMPTY(FIFOEMPTY),
        .FLUSH    (FLUSH),
        .SCSI_CS  (SCSI_CS),
        .RE       (RE),
        .WE       (WE),
        .DACK     (DACK),
        .S2CPU    (S2CPU),
        .CPU2S    (CPU2S),
        .S2F      (S2F),
        .F2S      (F2S),
        .DSACK    (DSACK),
        .INCBO    (INCBO),
        .INCNI    (INCNI),
        .INCNO    (INCNO),
        .LANE     (LANE)
    );

    always #5 CPUCLK = ~CPUCLK;

    assign outs = {SCSI_CS, RE, WE, DACK, S2CPU, CPU2S, S2F, F2S, DSACK, INCBO, INCNI, INCNO};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CPUCLK);
        #1;
    endtask

    task automatic step(input string tag, input logic [11:0] exp);
        tick();
        check_eq(tag, {20'b0, outs}, {20'b0, exp});
    endtask

    task automatic check_lane(input string tag, input int exp);
        check_eq(tag, {30'b0, LANE}, 32'(exp));
    endtask

    // Runs n back-to-back DMA bytes from idle; lane0 is the lane before the first byte.
    task automatic dma_bytes(input int n, input logic dir, input int lane0);
        logic [11:0] steer, strb, inc;
        int lane;
        steer  = dir ? O_S2F : O_F2S;
        strb   = dir ? O_RE : O_WE;
        inc    = dir ? O_INCNI : O_INCNO;
        lane   = lane0;
        DMADIR = dir;
        DREQ_  = 1'b0;
        step("dma_sync", 12'h000);
        for (int i = 0; i < n; i++) begin
            step("dma_setup", O_DACK | steer);
            step("dma_strobe1", O_DACK | steer | strb);
            step("dma_strobe2", O_DACK | steer | strb);
            step("dma_recov", O_INCBO | ((lane == 3) ? inc : 12'h000));
            lane = (lane + 1) % 4;
            check_lane("dma_lane", lane);
            if (i == n - 1) DREQ_ = 1'b1;
            step("dma_gap1", 12'h000);
            step("dma_gap2", 12'h000);
        end
    endtask

    initial begin
        RESET = 1'b1; CPUREQ = 1'b0; RW = 1'b0; DMADIR = 1'b0; DREQ_ = 1'b1;
        FIFOFULL = 1'b0; FIFOEMPTY = 1'b0; FLUSH = 1'b0;
        #2;
        check_eq("reset_outs", {20'b0, outs}, 32'h0);
        check_lane("reset_lane", 0);
        tick();
        tick();
        RESET = 1'b0;
        step("idle", 12'h000);

        // CPU read
        RW = 1'b1; CPUREQ = 1'b1;
        step("rd_e0", 12'h000);
        step("rd_e1", O_CS | O_S2CPU);
        step("rd_e2", O_CS | O_RE | O_S2CPU);
        step("rd_e3", O_CS | O_RE | O_S2CPU);
        step("rd_e4", O_DSACK | O_S2CPU);
        step("rd_hold", O_DSACK | O_S2CPU);
        CPUREQ = 1'b0;
        step("rd_ack_tail", O_DSACK | O_S2CPU);
        step("rd_idle", 12'h000);

        // CPU write; RW flips after it is latched and must be ignored
        RW = 1'b0; CPUREQ = 1'b1;
        step("wr_e0", 12'h000);
        step("wr_e1", O_CS | O_CPU2S);
        RW = 1'b1;
        step("wr_e2", O_CS | O_WE | O_CPU2S);
        step("wr_e3", O_CS | O_WE | O_CPU2S);
        step("wr_ack", O_DSACK);
        CPUREQ = 1'b0;
        step("wr_ack_tail", O_DSACK);
        step("wr_idle", 12'h000);
        check_lane("wr_lane", 0);

        // Eight SCSI->FIFO bytes: INCNI on bytes 4 and 8
        dma_bytes(8, 1'b1, 0);
        check_lane("dma8_lane", 0);

        // FIFO->SCSI blocked by FIFOEMPTY, then released
        DMADIR = 1'b0; FIFOEMPTY = 1'b1; DREQ_ = 1'b0;
        for (int i = 0; i < 5; i++) step("blocked", 12'h000);
        FIFOEMPTY = 1'b0;
        step("unblock_setup", O_DACK | O_F2S);
        DMADIR = 1'b1;
        step("unblock_strobe1", O_DACK | O_F2S | O_WE);
        step("unblock_strobe2", O_DACK | O_F2S | O_WE);
        step("unblock_recov", O_INCBO);
        check_lane("unblock_lane", 1);
        DREQ_ = 1'b1;
        step("unblock_gap1", 12'h000);
        step("unblock_gap2", 12'h000);

        // CPU and DMA requested together: CPU first
        RW = 1'b1; CPUREQ = 1'b1; DREQ_ = 1'b0;
        step("both_e0", 12'h000);
        step("both_cpu_setup", O_CS | O_S2CPU);
        step("both_cpu_strobe1", O_CS | O_RE | O_S2CPU);
        step("both_cpu_strobe2", O_CS | O_RE | O_S2CPU);
        step("both_cpu_ack", O_DSACK | O_S2CPU);
        CPUREQ = 1'b0;
        step("both_cpu_ack_tail", O_DSACK | O_S2CPU);
        step("both_idle1", 12'h000);
        step("both_idle2", 12'h000);
        step("both_dma_setup", O_DACK | O_S2F);
        step("both_dma_strobe1", O_DACK | O_S2F | O_RE);
        step("both_dma_strobe2", O_DACK | O_S2F | O_RE);
        step("both_dma_recov", O_INCBO);
        check_lane("both_lane", 2);
        DREQ_ = 1'b1;
        step("both_gap1", 12'h000);
        step("both_gap2", 12'h000);

        // Asynchronous reset in the middle of a DMA strobe
        DREQ_ = 1'b0;
        step("rs_e0", 12'h000);
        step("rs_setup", O_DACK | O_S2F);
        step("rs_strobe", O_DACK | O_S2F | O_RE);
        #2 RESET = 1'b1;
        #1;
        check_eq("rs_async_outs", {20'b0, outs}, 32'h0);
        check_lane("rs_async_lane", 0);
        #1 RESET = 1'b0;
        DREQ_ = 1'b1;
        for (int i = 0; i < 3; i++) step("rs_after", 12'h000);
        check_lane("rs_after_lane", 0);

        // Partial word then FLUSH
        dma_bytes(3, 1'b1, 0);
        check_lane("pre_flush_lane", 3);
        FLUSH = 1'b1;
`ifdef SCSI_XFER_FLUSH_EN
        step("flush_pulse", O_INCNI);
        FLUSH = 1'b0;
        check_lane("flush_lane", 0);
        step("flush_after", 12'h000);
        check_lane("flush_after_lane", 0);
`else
        step("flush_pulse", 12'h000);
        FLUSH = 1'b0;
        check_lane("flush_lane", 3);
        step("flush_after", 12'h000);
        check_lane("flush_after_lane", 3);
`endif
        FLUSH = 1'b1;
        step("flush_ignored", 12'h000);
        FLUSH = 1'b0;
        step("flush_ignored_after", 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
